uart_tx_ctrl: RTL and testbench

- Transmit sequencer that drains the 16-entry UART TX FIFO and serializes each byte onto the TXD line.
- Frame format: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits. The bit period is set by a programmable clock divisor.
- Sits between the TX FIFO (read side) and the pad. It owns the FIFO pop strobe and reports busy, done and frame-count status.

---
 rtl/uart_tx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serialises them onto txd.
// Optional parity stage is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tx_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_stop2,
`ifdef UART_TX_PARITY_EN
    input  logic             cfg_par_en,
    input  logic             cfg_par_odd,
`endif
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_pop,
    output logic             txd,
    output logic             busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop2_q;
    logic             txd_q, txd_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             tick;
`ifdef UART_TX_PARITY_EN
    logic             par_en_q;
    logic             par_bit_q;
`endif

    // Shadowed divisor keeps the bit period fixed for the whole frame.
    assign tick = (baud_cnt_q == div_q - DIV_ONE);

    // Pop is qualified with rstn so nothing is consumed while reset is held.
    assign fifo_pop = rstn && (state_q == S_IDLE) && tx_en && !fifo_empty;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = '0;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        txd_d       = 1'b1;

        if (state_q != S_IDLE) begin
            baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    state_d    = S_START;
                    shift_d    = fifo_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered from the next state so it lines up with state_q.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_bit_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            div_q       <= DIV_ONE;
            stop2_q     <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            if (fifo_pop) begin
                div_q   <= (cfg_div == '0) ? DIV_ONE : cfg_div;
                stop2_q <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
                par_en_q  <= cfg_par_en;
                par_bit_q <= (^fifo_data) ^ cfg_par_odd;
`endif
            end
        end
    end

    assign txd       = txd_q;
    assign busy      = (state_q != S_IDLE);
    assign tx_done   = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with a small queue-based FIFO model.
// Parity cases are compiled in when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;

    localparam int DIV_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             tx_en = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_stop2 = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_data = '0;
    logic             fifo_pop;
    logic             txd;
    logic             busy;
    logic             tx_done;
    logic [CNT_W-1:0] frame_cnt;
`ifdef UART_TX_PARITY_EN
    logic             cfg_par_en = 1'b0;
    logic             cfg_par_odd = 1'b0;
`endif

    int         checks = 0;
    int         failures = 0;
    int         pop_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] fifo_q[$];

    uart_tx_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_en      (tx_en),
        .cfg_div    (cfg_div),
        .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_PARITY_EN
        .cfg_par_en (cfg_par_en),
        .cfg_par_odd(cfg_par_odd),
`endif
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    // FIFO read side: a pop seen at a negedge is consumed just after the next posedge.
    initial forever begin
        @(negedge clk);
        if (fifo_pop === 1'b1) begin
            pop_cnt++;
            @(posedge clk);
            #1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            refresh_fifo();
        end
    end

    initial forever begin
        @(negedge clk);
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        tx_en     = 1'b0;
        cfg_div   = '0;
        cfg_stop2 = 1'b0;
        fifo_q.delete();
        refresh_fifo();
        repeat (2) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        pop_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where fifo_pop is high.
    task automatic wait_pop(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fifo_pop === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({tag, "_pop_timeout"}, 0, 1);
    endtask

    // Starts at the negedge before the pop edge; samples txd once per clock over
    // the whole frame, then checks the tx_done cycle. chg_at >= 0 applies the
    // mid-frame config/enable change at that sample index.
    task automatic check_frame(input string tag, input logic [7:0] data, input int div,
                               input bit stop2, input bit par_en, input bit par_odd,
                               input int chg_at);
        logic [11:0]  fb;
        logic [127:0] expv;
        logic [127:0] obs;
        bit           busy_all;
        int           nb;
        fb       = '1;
        fb[0]    = 1'b0;
        fb[8:1]  = data;
        if (par_en) fb[9] = (^data) ^ par_odd;
        nb       = 10 + int'(par_en) + int'(stop2);
        expv     = '0;
        obs      = '0;
        busy_all = 1'b1;
        for (int i = 0; i < nb * div; i++) expv[i] = fb[i / div];
        for (int i = 0; i < nb * div; i++) begin
            @(negedge clk);
            obs[i] = txd;
            if (busy !== 1'b1) busy_all = 1'b0;
            if (i == chg_at) begin
                cfg_div = 16'd8;
                tx_en   = 1'b0;
                push(8'h81);
            end
        end
        check({tag, "_bits"}, obs, expv);
        check({tag, "_busy"}, busy_all, 1);
        @(negedge clk);
        check({tag, "_done"}, tx_done, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bit ok;
        bit idle_ok;

        // Reset and idle with an empty FIFO.
        do_reset();
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        idle_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_line", idle_ok, 1);
        check("idle_pops", pop_cnt, 0);
        check("idle_cnt", frame_cnt, 0);

        // Single byte 0xA5, div 4, one stop bit.
        do_reset();
        @(posedge clk);
        #1;
        cfg_div = 16'd4;
        tx_en   = 1'b1;
        push(8'hA5);
        @(negedge clk);
        wait_pop("a5", ok);
        if (ok) check_frame("a5", 8'hA5, 4, 1'b0, 1'b0, 1'b0, -1);
        check("a5_cnt", frame_cnt, 1);
        @(negedge clk);
        check("a5_done_pulse", tx_done, 0);
        check("a5_pops", pop_cnt, 1);
        check("a5_dones", done_cnt, 1);

        // Back-to-back: 0x00, 0xFF, 0x55 with div 2 and two stop bits.
        do_reset();
        @(posedge clk);
        #1;
        cfg_div   = 16'd2;
        cfg_stop2 = 1'b1;
        tx_en     = 1'b1;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        @(negedge clk);
        wait_pop("b2b0", ok);
        if (ok) check_frame("b2b0", 8'h00, 2, 1'b1, 1'b0, 1'b0, -1);
        check("b2b0_gap_pop", fifo_pop, 1);
        wait_pop("b2b1", ok);
        if (ok) check_frame("b2b1", 8'hFF, 2, 1'b1, 1'b0, 1'b0, -1);
        check("b2b1_gap_pop", fifo_pop, 1);
        wait_pop("b2b2", ok);
        if (ok) check_frame("b2b2", 8'h55, 2, 1'b1, 1'b0, 1'b0, -1);
        check("b2b2_gap_pop", fifo_pop, 0);
        check("b2b_cnt", frame_cnt, 3);
        check("b2b_pops", pop_cnt, 3);

        // Mid-frame divisor change and tx_en drop during DATA of 0x3C.
        do_reset();
        @(posedge clk);
        #1;
        cfg_div = 16'd4;
        tx_en   = 1'b1;
        push(8'h3C);
        @(negedge clk);
        wait_pop("mid", ok);
        if (ok) check_frame("mid", 8'h3C, 4, 1'b0, 1'b0, 1'b0, 13);
        check("mid_cnt", frame_cnt, 1);
        repeat (30) @(negedge clk);
        check("mid_no_pop", pop_cnt, 1);
        check("mid_idle_txd", txd, 1);
        check("mid_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        tx_en = 1'b1;
        @(negedge clk);
        wait_pop("newdiv", ok);
        if (ok) check_frame("newdiv", 8'h81, 8, 1'b0, 1'b0, 1'b0, -1);
        check("newdiv_cnt", frame_cnt, 2);

        // Reset during DATA bit 3 of 0x52 (bit 3 = 0, so txd is low before reset).
        do_reset();
        @(posedge clk);
        #1;
        cfg_div = 16'd4;
        tx_en   = 1'b1;
        push(8'h52);
        @(negedge clk);
        wait_pop("rmid", ok);
        repeat (18) @(negedge clk);
        check("rmid_pre_txd", txd, 0);
        push(8'h99);
        #2;
        rstn = 1'b0;
        #1;
        check("rmid_txd", txd, 1);
        check("rmid_busy", busy, 0);
        check("rmid_pop", fifo_pop, 0);
        check("rmid_done", tx_done, 0);
        check("rmid_cnt", frame_cnt, 0);
        tx_en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("rmid_dones", done_cnt, 0);
        check("rmid_pops", pop_cnt, 1);
        check("rmid_cnt_after", frame_cnt, 0);

        // cfg_div = 0 behaves as one clock per bit.
        do_reset();
        @(posedge clk);
        #1;
        cfg_div = '0;
        tx_en   = 1'b1;
        push(8'hC3);
        @(negedge clk);
        wait_pop("div0", ok);
        if (ok) check_frame("div0", 8'hC3, 1, 1'b0, 1'b0, 1'b0, -1);
        check("div0_cnt", frame_cnt, 1);

`ifdef UART_TX_PARITY_EN
        // 0xA5 has four ones: even parity 0, odd parity 1; 11-clock frames.
        do_reset();
        @(posedge clk);
        #1;
        cfg_div     = 16'd1;
        cfg_par_en  = 1'b1;
        cfg_par_odd = 1'b0;
        tx_en       = 1'b1;
        push(8'hA5);
        @(negedge clk);
        wait_pop("par_even", ok);
        if (ok) check_frame("par_even", 8'hA5, 1, 1'b0, 1'b1, 1'b0, -1);
        @(posedge clk);
        #1;
        cfg_par_odd = 1'b1;
        push(8'hA5);
        @(negedge clk);
        wait_pop("par_odd", ok);
        if (ok) check_frame("par_odd", 8'hA5, 1, 1'b0, 1'b1, 1'b1, -1);
        check("par_cnt", frame_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
